// File: rtl/sum_display_pkg.sv
// Shared constants, FSM encoding and the double-dabble digit adjust used by
// the sum_display binary-to-decimal display block.
package sum_display_pkg;

    // Six decimal digits hold 2^17-1 = 131071, the largest value at N=16
    localparam int NUM_DIGITS = 6;
    localparam int BCD_W      = 4 * NUM_DIGITS;

    // Iteration counter must reach N+1 = 17 at the widest operand
    localparam int CNT_W = 5;

    // Active-low segments {g,f,e,d,c,b,a}; all ones is a dark digit
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LOAD  = 2'd2
    } state_e;

    // Add 3 to every BCD digit that is 5 or more, so that the following
    // left shift carries correctly into the next decimal digit.
    function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] s);
        logic [BCD_W-1:0] r;
        r = s;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (s[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = s[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sum_display_seg7_dec.sv
// BCD digit to active-low 7-segment pattern; codes above 9 show dark.
module seg7_dec
    import sum_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Pure lookup, segment order {g,f,e,d,c,b,a}
    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0: seg = 7'b1000000;
            4'd1: seg = 7'b1111001;
            4'd2: seg = 7'b0100100;
            4'd3: seg = 7'b0110000;
            4'd4: seg = 7'b0011001;
            4'd5: seg = 7'b0010010;
            4'd6: seg = 7'b0000010;
            4'd7: seg = 7'b1111000;
            4'd8: seg = 7'b0000000;
            4'd9: seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/sum_display.sv
// Shows the adder result {cout, sum} in decimal on six 7-segment digits.
// A sequential double-dabble converter runs whenever the value changes;
// the display only ever follows the committed result register, so it
// never flickers while a conversion is in flight.
module sum_display
    import sum_display_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         CLOCK_50,
    input  logic         resetn,
    input  logic [N-1:0] sum,
    input  logic         cout,
    output logic         busy,
    output logic [6:0]   HEX0,
    output logic [6:0]   HEX1,
    output logic [6:0]   HEX2,
    output logic [6:0]   HEX3,
    output logic [6:0]   HEX4,
    output logic [6:0]   HEX5
);

    localparam int VW = N + 1;

    logic [VW-1:0]    value;
    state_e           state_q,   state_d;
    logic [VW-1:0]    cap_q,     cap_d;      // value being / last converted
    logic [VW-1:0]    shreg_q,   shreg_d;    // working copy shifted out MSB first
    logic [BCD_W-1:0] scr_q,     scr_d;      // BCD scratch accumulating digits
    logic [BCD_W-1:0] res_q,     res_d;      // committed result driving the HEX
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             first_q,   first_d;    // forces a conversion after reset
    logic             res_vld_q, res_vld_d;  // keeps digits dark until first result

    logic                           start;
    logic [NUM_DIGITS-1:0][6:0]     seg_raw;
    logic [NUM_DIGITS-1:0][6:0]     hex_w;
    logic [NUM_DIGITS-1:0]          lead_blank;
    logic                           nz_above;

    assign value = {cout, sum};
    assign start = (value != cap_q) || first_q;

    // State and datapath registers; reset aborts any conversion at once
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            cap_q     <= '0;
            shreg_q   <= '0;
            scr_q     <= '0;
            res_q     <= '0;
            cnt_q     <= '0;
            first_q   <= 1'b1;
            res_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cap_q     <= cap_d;
            shreg_q   <= shreg_d;
            scr_q     <= scr_d;
            res_q     <= res_d;
            cnt_q     <= cnt_d;
            first_q   <= first_d;
            res_vld_q <= res_vld_d;
        end
    end

    // Next state: IDLE waits for a new value, SHIFT runs N+1 times, LOAD commits
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_SHIFT;
            ST_SHIFT: if (cnt_q <= CNT_W'(1)) state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath updates per state; inputs are only sampled in IDLE
    always_comb begin
        cap_d     = cap_q;
        shreg_d   = shreg_q;
        scr_d     = scr_q;
        res_d     = res_q;
        cnt_d     = cnt_q;
        first_d   = first_q;
        res_vld_d = res_vld_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cap_d   = value;
                    shreg_d = value;
                    scr_d   = '0;
                    cnt_d   = CNT_W'(VW);
                    first_d = 1'b0;
                end
            end
            ST_SHIFT: begin
                scr_d   = (bcd_adjust(scr_q) << 1) | BCD_W'(shreg_q[VW-1]);
                shreg_d = shreg_q << 1;
                cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_LOAD: begin
                res_d     = scr_q;
                res_vld_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy = (state_q != ST_IDLE);

    // Mark upper digits that are leading zeros; digit 0 is always shown
    always_comb begin
        lead_blank = '0;
        nz_above   = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (res_q[4*i +: 4] != 4'd0) nz_above = 1'b1;
            lead_blank[i] = !nz_above;
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
        seg7_dec u_dec (
            .bcd (res_q[4*g +: 4]),
            .seg (seg_raw[g])
        );
    end

    // Final digit mux: dark before the first result and for leading zeros
    always_comb begin
        hex_w = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            hex_w[i] = (!res_vld_q || lead_blank[i]) ? SEG_BLANK : seg_raw[i];
        end
    end

    assign HEX0 = hex_w[0];
    assign HEX1 = hex_w[1];
    assign HEX2 = hex_w[2];
    assign HEX3 = hex_w[3];
    assign HEX4 = hex_w[4];
    assign HEX5 = hex_w[5];

endmodule

// File: tb/tb_sum_display.sv
// Bench for sum_display: one N=4 and one N=16 instance on a shared clock and
// reset, a result scoreboard per instance plus timing and reset checks.
module tb_sum_display;

    logic        clk;
    logic        rst_n;
    logic [3:0]  sum4;
    logic        cout4;
    logic [15:0] sum16;
    logic        cout16;
    logic        busy4, busy16;
    logic [6:0]  h4_0, h4_1, h4_2, h4_3, h4_4, h4_5;
    logic [6:0]  h16_0, h16_1, h16_2, h16_3, h16_4, h16_5;
    logic [41:0] hex4, hex16;

    int total = 0;
    int bad   = 0;
    int v4    = 0;
    int v16   = 0;
    logic [41:0] exp4_q[$];
    logic [41:0] exp16_q[$];
    logic [41:0] all_blank;

    sum_display #(.N(4)) u_dut4 (
        .CLOCK_50 (clk), .resetn (rst_n), .sum (sum4), .cout (cout4), .busy (busy4),
        .HEX0 (h4_0), .HEX1 (h4_1), .HEX2 (h4_2), .HEX3 (h4_3), .HEX4 (h4_4), .HEX5 (h4_5)
    );

    sum_display #(.N(16)) u_dut16 (
        .CLOCK_50 (clk), .resetn (rst_n), .sum (sum16), .cout (cout16), .busy (busy16),
        .HEX0 (h16_0), .HEX1 (h16_1), .HEX2 (h16_2), .HEX3 (h16_3), .HEX4 (h16_4), .HEX5 (h16_5)
    );

    assign hex4  = {h4_5, h4_4, h4_3, h4_2, h4_1, h4_0};
    assign hex16 = {h16_5, h16_4, h16_3, h16_2, h16_1, h16_0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    // Decimal rendering of v with leading-zero blanking, {HEX5..HEX0}
    function automatic logic [41:0] exp_hex(input int v);
        logic [41:0] r;
        int x;
        r = '1;
        x = v;
        for (int i = 0; i < 6; i++) begin
            if (i == 0 || x != 0) r[7*i +: 7] = seg_of(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive both instances; a changed value means one more result to expect
    task automatic drive(input int a, input int b);
        if (a != v4) exp4_q.push_back(exp_hex(a));
        if (b != v16) exp16_q.push_back(exp_hex(b));
        v4 = a;
        v16 = b;
        {cout4, sum4}   = 5'(a);
        {cout16, sum16} = 17'(b);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy4 && !busy16) break;
        end
        chk("idle", {62'd0, busy4, busy16}, 64'd0);
        step(1);
    endtask

    // Scoreboard monitors: each falling busy delivers one result
    logic pb4 = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) pb4 = 1'b0;
        else begin
            if (pb4 && !busy4) begin
                if (exp4_q.size() == 0) chk("sb4_pending", 64'(exp4_q.size()), 64'd1);
                else chk("sb4_result", 64'(hex4), 64'(exp4_q.pop_front()));
            end
            pb4 = busy4;
        end
    end

    logic pb16 = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) pb16 = 1'b0;
        else begin
            if (pb16 && !busy16) begin
                if (exp16_q.size() == 0) chk("sb16_pending", 64'(exp16_q.size()), 64'd1);
                else chk("sb16_result", 64'(hex16), 64'(exp16_q.pop_front()));
            end
            pb16 = busy16;
        end
    end

    int list4[8]  = '{10, 0, 1, 20, 7, 7, 16, 30};
    int list16[8] = '{10, 100000, 99999, 65536, 9, 12345, 12345, 0};
    int cnt4, cnt16;

    initial begin
        all_blank = '1;
        rst_n = 1'b0;
        {cout4, sum4} = '0;
        {cout16, sum16} = '0;
        step(3);
        chk("rst_busy", {62'd0, busy4, busy16}, 64'd0);
        chk("rst_hex4", 64'(hex4), 64'(all_blank));
        chk("rst_hex16", 64'(hex16), 64'(all_blank));

        // Release with V=0: the first conversion must still run
        rst_n = 1'b1;
        exp4_q.push_back(exp_hex(0));
        exp16_q.push_back(exp_hex(0));
        cnt4 = 0;
        cnt16 = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy4) cnt4++;
            if (busy16) cnt16++;
        end
        chk("busy_len4", 64'(cnt4), 64'd6);
        chk("busy_len16", 64'(cnt16), 64'd18);
        chk("zero_hex4", 64'(hex4), 64'(exp_hex(0)));
        chk("zero_hex16", 64'(hex16), 64'(exp_hex(0)));
        step(1);

        // Maximum values on both widths, with exact latency
        drive(31, 131071);
        step(6);
        chk("lat4_early", 64'(hex4), 64'(exp_hex(0)));
        step(1);
        chk("lat4_31", 64'(hex4), 64'(exp_hex(31)));
        chk("lat4_busy", 64'(busy4), 64'd0);
        step(11);
        chk("lat16_early", 64'(hex16), 64'(exp_hex(0)));
        step(1);
        chk("lat16_max", 64'(hex16), 64'(exp_hex(131071)));
        chk("lat16_busy", 64'(busy16), 64'd0);
        step(1);

        // Input change mid-SHIFT is ignored, then picked up after LOAD
        drive(9, v16);
        step(2);
        drive(3, v16);
        step(5);
        chk("mid_9", 64'(hex4), 64'(exp_hex(9)));
        chk("mid_idle", 64'(busy4), 64'd0);
        step(1);
        chk("mid_restart", 64'(busy4), 64'd1);
        step(6);
        chk("mid_3", 64'(hex4), 64'(exp_hex(3)));

        // Stable value: no reconversion
        cnt4 = 0;
        cnt16 = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy4) cnt4++;
            if (busy16) cnt16++;
        end
        chk("hold_busy", 64'(cnt4 + cnt16), 64'd0);
        step(1);

        // Mixed patterns through the scoreboard
        for (int i = 0; i < 8; i++) begin
            drive(list4[i], list16[i]);
            step(1);
            wait_idle(40);
        end
        chk("list_hex4", 64'(hex4), 64'(exp_hex(v4)));
        chk("list_hex16", 64'(hex16), 64'(exp_hex(v16)));

        // Reset in the middle of a conversion of 31
        drive(31, v16);
        step(3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {62'd0, busy4, busy16}, 64'd0);
        chk("abort_hex4", 64'(hex4), 64'(all_blank));
        chk("abort_hex16", 64'(hex16), 64'(all_blank));
        exp4_q.delete();
        exp16_q.delete();
        step(2);
        rst_n = 1'b1;
        exp4_q.push_back(exp_hex(v4));
        exp16_q.push_back(exp_hex(v16));
        step(6);
        chk("rearm_dark", 64'(hex4), 64'(all_blank));
        step(1);
        chk("rearm_31", 64'(hex4), 64'(exp_hex(31)));
        wait_idle(40);
        step(2);

        chk("sb4_empty", 64'(exp4_q.size()), 64'd0);
        chk("sb16_empty", 64'(exp16_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute guard so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
